// File: rtl/rng_pkg.sv
// Shared types and defaults for the LFSR draw arbiter.
// Tap positions give the primitive polynomial x^10 + x^7 + 1.
package rng_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        REDUCE = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int             DEF_WIDTH       = 10;
    localparam logic [9:0]     DEF_SEED        = 10'h3FF;
    localparam int             DEF_STEP_SHIFTS = 10;
    localparam int             TAP_HI          = 9;
    localparam int             TAP_LO          = 6;

endpackage

// File: rtl/lfsr10.sv
// Free-running 10-bit Fibonacci LFSR; shifts every cycle and reloads SEED
// if it ever lands in the all-zero lock-up state.
module lfsr10
    import rng_pkg::*;
#(
    parameter logic [9:0] SEED = DEF_SEED
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] lfsr
);

    logic [9:0] lfsr_q;
    logic [9:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[8:0], lfsr_q[TAP_HI] ^ lfsr_q[TAP_LO]};
        if (lfsr_q == '0) begin
            lfsr_d = SEED;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/rng_arbiter.sv
// Round-robin arbiter sharing one LFSR between requesters; spaces captures by
// STEP_SHIFTS shifts and folds each draw into the requester's range.
module rng_arbiter
    import rng_pkg::*;
#(
    parameter int               N_REQ       = 3,
    parameter int               WIDTH       = DEF_WIDTH,
    parameter logic [WIDTH-1:0] SEED        = DEF_SEED,
    parameter int               STEP_SHIFTS = DEF_STEP_SHIFTS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] limit,
    output logic [N_REQ-1:0]       ack,
    output logic [WIDTH-1:0]       rnd,
    output logic                   busy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(STEP_SHIFTS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STEP_SHIFTS);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   grant_q, grant_d;
    logic [WIDTH-1:0]   lim_q, lim_d;
    logic [WIDTH-1:0]   val_q, val_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [WIDTH-1:0]   rnd_q, rnd_d;

    logic [WIDTH-1:0]   lfsr_val;
    logic [WIDTH-1:0]   lim_arr [N_REQ];
    logic [PTR_W-1:0]   pick;
    logic [PTR_W-1:0]   cand;
    logic [WIDTH:0]     lim_p1;

    lfsr10 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .lfsr  (lfsr_val)
    );

    for (genvar i = 0; i < N_REQ; i++) begin : g_lim
        assign lim_arr[i] = limit[i*WIDTH +: WIDTH];
    end

    // Scan from the far end back toward ptr so the nearest requester wins.
    always_comb begin
        pick = ptr_q;
        cand = ptr_q;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = PTR_W'((int'(ptr_q) + k) % N_REQ);
            if (req[cand]) begin
                pick = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        lim_d   = lim_q;
        val_d   = val_q;
        ack_d   = '0;
        rnd_d   = rnd_q;
        cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        lim_p1  = {1'b0, lim_q} + (WIDTH + 1)'(1);

        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d = pick;
                    lim_d   = lim_arr[pick];
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_MAX) begin
                    val_d   = lfsr_val;
                    cnt_d   = '0;
                    state_d = REDUCE;
                end
            end
            REDUCE: begin
                // A full-range limit makes lim_p1 = 2^WIDTH, so this always holds.
                if ({1'b0, val_q} < lim_p1) begin
                    ack_d[grant_q] = 1'b1;
                    rnd_d          = val_q;
                    state_d        = DONE;
                end else begin
                    val_d = val_q - lim_p1[WIDTH-1:0];
                end
            end
            DONE: begin
                ptr_d   = (grant_q == PTR_LAST) ? '0 : grant_q + PTR_W'(1);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            lim_q   <= '0;
            val_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            lim_q   <= lim_d;
            val_q   <= val_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            rnd_q   <= rnd_d;
        end
    end

    assign ack  = ack_q;
    assign rnd  = rnd_q;
    assign busy = (state_q != IDLE);

endmodule
